// File: rtl/laplacian_stream_scheduler.sv
// Frame-level sequencer for an external Laplacian cross kernel (4*p5 - p2 - p4 - p6 - p8).
// Accepts a raster-order pixel stream, buffers the two previous lines, presents the 3x3 cross
// window to the kernel and registers one result per interior image position.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle pulse that begins a frame; honoured only when idle
//   in_valid/in_ready   source handshake; in_pixel is the raster-order source pixel
//   k_p2..k_p8          window taps driven to the kernel (north, west, centre, east, south)
//   k_y                 combinational kernel result for the current taps
//   out_valid/out_ready sink handshake; out_pixel is the held result
//   out_last            marks the final result of a frame
//   busy                a frame is in progress
//   done                one-cycle pulse after the final result has been accepted
module laplacian_stream_scheduler #(
    parameter int unsigned IMG_W = 64,
    parameter int unsigned IMG_H = 64,
    parameter int unsigned DW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_pixel,
    output logic [DW-1:0] k_p2,
    output logic [DW-1:0] k_p4,
    output logic [DW-1:0] k_p5,
    output logic [DW-1:0] k_p6,
    output logic [DW-1:0] k_p8,
    input  logic [DW-1:0] k_y,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_pixel,
    output logic          out_last,
    output logic          busy,
    output logic          done
);

    localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

    state_e state_q, state_d;

    logic [RW-1:0] row_q;
    logic [CW-1:0] col_q;

    // lb1_q holds line r-1 and lb2_q line r-2 at the column about to be accepted; each slot
    // is overwritten only once its old value has been moved down a line.
    logic [DW-1:0] lb1_q [IMG_W];
    logic [DW-1:0] lb2_q [IMG_W];

    // Column taps: values read out of the line buffers (and the input) at earlier columns.
    logic [DW-1:0] n_tap_q;   // line r-2, column c-1
    logic [DW-1:0] w0_tap_q;  // line r-1, column c-1
    logic [DW-1:0] w1_tap_q;  // line r-1, column c-2
    logic [DW-1:0] s_tap_q;   // line r,   column c-1

    logic          out_valid_q;
    logic          out_last_q;
    logic [DW-1:0] out_pixel_q;

    logic accept;
    logic last_pix;
    logic interior;

    always_comb begin
        in_ready = (state_q == StRun) && (!out_valid_q || out_ready);
        accept   = in_valid && in_ready;
        last_pix = (row_q == ROW_LAST) && (col_q == COL_LAST);
        // Rows 0-1 and columns 0-1 never complete a window, so stale line data is never used.
        interior = (row_q >= RW'(2)) && (col_q >= CW'(2));
        busy     = (state_q != StIdle);
        done     = (state_q == StDone);
        k_p2     = n_tap_q;
        k_p4     = w1_tap_q;
        k_p5     = w0_tap_q;
        k_p6     = lb1_q[col_q];
        k_p8     = s_tap_q;
        out_valid = out_valid_q;
        out_last  = out_last_q;
        out_pixel = out_pixel_q;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (accept && last_pix) state_d = StFlush;
            StFlush: if (out_valid_q && out_ready) state_d = StDone;
            StDone:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Position counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else if (state_q == StIdle && start) begin
            row_q <= '0;
            col_q <= '0;
        end else if (accept) begin
            if (col_q == COL_LAST) begin
                col_q <= '0;
                row_q <= row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

    // Line buffers and column taps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < IMG_W; i++) begin
                lb1_q[i] <= '0;
                lb2_q[i] <= '0;
            end
            n_tap_q  <= '0;
            w0_tap_q <= '0;
            w1_tap_q <= '0;
            s_tap_q  <= '0;
        end else if (accept) begin
            lb2_q[col_q] <= lb1_q[col_q];
            lb1_q[col_q] <= in_pixel;
            n_tap_q      <= lb2_q[col_q];
            w1_tap_q     <= w0_tap_q;
            w0_tap_q     <= lb1_q[col_q];
            s_tap_q      <= in_pixel;
        end
    end

    // Output register: a new interior result may replace the held one in the same cycle it
    // is consumed, because in_ready already requires the old one to be leaving.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_pixel_q <= '0;
        end else if (accept && interior) begin
            out_valid_q <= 1'b1;
            out_last_q  <= last_pix;
            out_pixel_q <= k_y;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end
    end

endmodule
